// File: rtl/spi_nibble_scheduler_pkg.sv
// Shared types and constants for the SPI nibble scheduler.
// Slot state encoding plus the grant/tag marker values.
package spi_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   localparam int         SLOT_BITS  = 4;
   localparam logic [2:0] GRANT_NONE = 3'd7;
   localparam logic [3:0] TAG_IDLE   = 4'h8;

endpackage

// File: rtl/spi_nibble_scheduler_if.sv
// Producer-side handshake bundle: valid/data in, ready/grant back.
// The scheduler takes the slave end, the producers the master end.
interface spi_nibble_scheduler_if #(
   parameter int NREQ = 4
);

   logic [NREQ-1:0]   req_valid;
   logic [4*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [2:0]        grant_id;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  grant_id
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output grant_id
   );

endinterface

// File: rtl/spi_nibble_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after last.
// Produces a one-hot grant, its index, and an any-grant flag.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] valid,
   input  logic [2:0]      last,
   output logic [NREQ-1:0] gnt,
   output logic [2:0]      idx,
   output logic            any
);

   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any &&
             |(valid & (ONE << ((int'(last) + k) % NREQ)))) begin
            any = 1'b1;
            gnt = ONE << ((int'(last) + k) % NREQ);
            idx = 3'((int'(last) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/spi_nibble_scheduler.sv
// SPI MISO nibble scheduler: preamble then round-robin data slots.
// Define SPI_NIBBLE_SCHED_TAG_EN to prefix each data slot with a tag slot.
module spi_nibble_scheduler
   import spi_sched_pkg::*;
#(
   parameter int         NREQ        = 4,
   parameter logic [3:0] IDLE_NIBBLE = 4'hF,
   parameter logic [3:0] PREAMBLE    = 4'hF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 SSEL,
   input  logic                 SCK,
   input  logic                 MOSI,
   inout  wire                  MISO,
   spi_nibble_scheduler_if.slave bus,
   output logic                 frame_active,
   output logic [7:0]           nibbles_sent
);

   state_t          state, state_nx;
   logic [1:0]      ssel_h, sck_h;
   logic [3:0]      shreg, shreg_nx;
   logic [1:0]      cnt, cnt_nx;
   logic [2:0]      last_grant, last_nx;
   logic [2:0]      grant_id, gid_nx;
   logic            granted, granted_nx;
   logic [7:0]      sent_nx;
   logic [NREQ-1:0] pick;
   logic [2:0]      pick_idx;
   logic            pick_any;
   logic [3:0]      pick_data;
   logic            ssel_fall, sck_fall, ssel_high;
   logic            miso_oe;
   logic            unused_ok;

`ifdef SPI_NIBBLE_SCHED_TAG_EN
   logic            tag_next, tag_nx;
   logic            hold_gr, hold_gr_nx;
   logic [3:0]      hold, hold_nx;
`endif

   assign unused_ok = MOSI;
   assign ssel_fall = ssel_h == 2'b10;
   assign sck_fall  = sck_h == 2'b10;
   assign ssel_high = ssel_h[0];
   assign pick_data = 4'(bus.req_data >> {pick_idx, 2'b00});
   assign miso_oe   = state == SHIFT;
   assign MISO      = miso_oe ? shreg[3] : 1'bz;
   assign bus.grant_id = grant_id;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .valid (bus.req_valid),
      .last  (last_grant),
      .gnt   (pick),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      state_nx      = state;
      shreg_nx      = shreg;
      cnt_nx        = cnt;
      last_nx       = last_grant;
      gid_nx        = grant_id;
      granted_nx    = granted;
      sent_nx       = nibbles_sent;
      bus.req_ready = '0;
`ifdef SPI_NIBBLE_SCHED_TAG_EN
      tag_nx        = tag_next;
      hold_nx       = hold;
      hold_gr_nx    = hold_gr;
`endif
      // SSEL high overrides any pending SCK edge in the same clock
      if (ssel_high) begin
         state_nx   = IDLE;
         granted_nx = 1'b0;
      end else begin
         unique case (state)
            IDLE: if (ssel_fall) begin
               state_nx   = SHIFT;
               shreg_nx   = PREAMBLE;
               cnt_nx     = '0;
               gid_nx     = GRANT_NONE;
               granted_nx = 1'b0;
`ifdef SPI_NIBBLE_SCHED_TAG_EN
               tag_nx     = 1'b1;
`endif
            end
            SHIFT: if (sck_fall) begin
               shreg_nx = {shreg[2:0], shreg[3]};
               cnt_nx   = cnt + 2'd1;
               if (cnt == 2'(SLOT_BITS - 1)) begin
                  state_nx = GAP;
                  if (granted) sent_nx = nibbles_sent + 8'd1;
               end
            end
            GAP: if (sck_fall) state_nx = LOAD;
            LOAD: begin
               state_nx = SHIFT;
               cnt_nx   = '0;
`ifdef SPI_NIBBLE_SCHED_TAG_EN
               if (tag_next) begin
                  bus.req_ready = pick;
                  tag_nx        = 1'b0;
                  granted_nx    = 1'b0;
                  hold_gr_nx    = pick_any;
                  if (pick_any) begin
                     shreg_nx = {1'b0, pick_idx};
                     hold_nx  = pick_data;
                     gid_nx   = pick_idx;
                     last_nx  = pick_idx;
                  end else begin
                     shreg_nx = TAG_IDLE;
                     hold_nx  = IDLE_NIBBLE;
                     gid_nx   = GRANT_NONE;
                  end
               end else begin
                  shreg_nx   = hold;
                  granted_nx = hold_gr;
                  tag_nx     = 1'b1;
               end
`else
               bus.req_ready = pick;
               granted_nx    = pick_any;
               if (pick_any) begin
                  shreg_nx = pick_data;
                  gid_nx   = pick_idx;
                  last_nx  = pick_idx;
               end else begin
                  shreg_nx = IDLE_NIBBLE;
                  gid_nx   = GRANT_NONE;
               end
`endif
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         ssel_h       <= 2'b00;
         sck_h        <= 2'b00;
         shreg        <= '0;
         cnt          <= '0;
         last_grant   <= 3'(NREQ - 1);
         grant_id     <= GRANT_NONE;
         granted      <= 1'b0;
         nibbles_sent <= '0;
         frame_active <= 1'b0;
`ifdef SPI_NIBBLE_SCHED_TAG_EN
         tag_next     <= 1'b0;
         hold         <= '0;
         hold_gr      <= 1'b0;
`endif
      end else begin
         state        <= state_nx;
         ssel_h       <= {ssel_h[0], SSEL};
         sck_h        <= {sck_h[0], SCK};
         shreg        <= shreg_nx;
         cnt          <= cnt_nx;
         last_grant   <= last_nx;
         grant_id     <= gid_nx;
         granted      <= granted_nx;
         nibbles_sent <= sent_nx;
         if (ssel_high)      frame_active <= 1'b0;
         else if (ssel_fall) frame_active <= 1'b1;
`ifdef SPI_NIBBLE_SCHED_TAG_EN
         tag_next     <= tag_nx;
         hold         <= hold_nx;
         hold_gr      <= hold_gr_nx;
`endif
      end
   end

endmodule
